csr_irq_unit: RTL and testbench

Parametrised machine-mode CSR file with an integrated CLINT-style timer and software interrupt source, plus an external interrupt input. It performs CSRRW/CSRRS/CSRRC operations, takes ecall traps and prioritised interrupts with direct or vectored mtvec dispatch, and handles mret. It sits beside the execute/writeback stage and gives the fetch stage its redirect target.

---
 rtl/csr_irq_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_csr_irq_unit.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_irq_unit.sv
// Machine-mode CSR file with a CLINT-style timer/software interrupt source,
// ecall/mret trap handling and direct or vectored mtvec dispatch.
module csr_irq_unit #(
  parameter int XLEN        = 64,
  parameter int MTIME_DIV   = 1,
  parameter int ECALL_CAUSE = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     csr_addr,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            illegal_csr,
  input  logic            insn_boundary,
  input  logic            ecall,
  input  logic            mret,
  input  logic [XLEN-1:0] epc,
  input  logic            irq_ext,
  input  logic            mmio_we,
  input  logic [4:0]      mmio_addr,
  input  logic [XLEN-1:0] mmio_wdata,
  output logic [XLEN-1:0] mmio_rdata,
  output logic            trap_take,
  output logic [XLEN-1:0] trap_target
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [XLEN-1:0] IRQ_FLAG   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] LOW2_MASK  = ~XLEN'(3);
  localparam logic [31:0]     PRESC_LAST = 32'(MTIME_DIV - 1);

  function automatic logic [XLEN-1:0] csr_apply(input logic [1:0] op,
                                                input logic [XLEN-1:0] old_v,
                                                input logic [XLEN-1:0] wd);
    case (op)
      OP_WRITE: csr_apply = wd;
      OP_SET:   csr_apply = old_v | wd;
      OP_CLEAR: csr_apply = old_v & ~wd;
      default:  csr_apply = old_v;
    endcase
  endfunction

  // Modes 2 and 3 are reserved: keep the current mode, take only the new base.
  function automatic logic [XLEN-1:0] mtvec_merge(input logic [XLEN-1:0] old_v,
                                                  input logic [XLEN-1:0] nv);
    mtvec_merge = {nv[XLEN-1:2], nv[1] ? old_v[1:0] : nv[1:0]};
  endfunction

  logic            st_mie, st_mpie;
  logic            ie_msi, ie_mti, ie_mei;
  logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic            msip_q;
  logic [63:0]     mtime_q, mtimecmp_q;
  logic [31:0]     presc_q;

  logic            mtip;
  logic [XLEN-1:0] mstatus_v, mie_v, mip_v;
  logic            csr_hit;
  logic [XLEN-1:0] csr_new;
  logic            pend_mei, pend_msi, pend_mti, irq_req;
  logic            take_ecall, take_mret, take_irq, csr_we;
  logic [3:0]      irq_cause;
  logic [XLEN-1:0] mtvec_base;
  logic [63:0]     mtime_d, mtimecmp_d;
  logic            msip_d;

  assign mtip = (mtime_q >= mtimecmp_q);

  always_comb begin
    mstatus_v        = '0;
    mstatus_v[12:11] = 2'b11;
    mstatus_v[7]     = st_mpie;
    mstatus_v[3]     = st_mie;
    mie_v            = '0;
    mie_v[11]        = ie_mei;
    mie_v[7]         = ie_mti;
    mie_v[3]         = ie_msi;
    mip_v            = '0;
    mip_v[11]        = irq_ext;
    mip_v[7]         = mtip;
    mip_v[3]         = msip_q;
  end

  always_comb begin
    csr_rdata = '0;
    csr_hit   = 1'b1;
    case (csr_addr)
      A_MSTATUS:  csr_rdata = mstatus_v;
      A_MIE:      csr_rdata = mie_v;
      A_MTVEC:    csr_rdata = mtvec_q;
      A_MSCRATCH: csr_rdata = mscratch_q;
      A_MEPC:     csr_rdata = mepc_q;
      A_MCAUSE:   csr_rdata = mcause_q;
      A_MIP:      csr_rdata = mip_v;
      default:    csr_hit   = 1'b0;
    endcase
  end

  assign illegal_csr = (csr_op != OP_NONE) && !csr_hit;
  assign csr_new     = csr_apply(csr_op, csr_rdata, csr_wdata);

  assign pend_mei   = irq_ext & ie_mei;
  assign pend_msi   = msip_q & ie_msi;
  assign pend_mti   = mtip & ie_mti;
  assign irq_req    = insn_boundary & st_mie & (pend_mei | pend_msi | pend_mti);
  assign irq_cause  = pend_mei ? 4'd11 : (pend_msi ? 4'd3 : 4'd7);
  assign take_ecall = ecall;
  assign take_mret  = !ecall && mret;
  assign take_irq   = !ecall && !mret && irq_req;
  assign csr_we     = (csr_op != OP_NONE) && csr_hit && !ecall && !mret && !irq_req;
  assign mtvec_base = mtvec_q & LOW2_MASK;

  always_comb begin
    trap_take   = 1'b0;
    trap_target = '0;
    if (!rst) begin
      if (take_ecall) begin
        trap_take   = 1'b1;
        trap_target = mtvec_base;
      end else if (take_mret) begin
        trap_take   = 1'b1;
        trap_target = mepc_q;
      end else if (take_irq) begin
        trap_take   = 1'b1;
        trap_target = mtvec_q[0] ? mtvec_base + XLEN'({irq_cause, 2'b00}) : mtvec_base;
      end
    end
  end

  // CLINT side: a software write to mtime replaces that cycle's increment.
  always_comb begin
    mtime_d    = mtime_q + ((presc_q == PRESC_LAST) ? 64'd1 : 64'd0);
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (mmio_we) begin
      case (mmio_addr)
        5'h00: msip_d = mmio_wdata[0];
        5'h08: begin
          if (XLEN == 64) mtimecmp_d = 64'(mmio_wdata);
          else            mtimecmp_d[31:0] = mmio_wdata[31:0];
        end
        5'h0C: if (XLEN == 32) mtimecmp_d[63:32] = mmio_wdata[31:0];
        5'h10: begin
          if (XLEN == 64) mtime_d = 64'(mmio_wdata);
          else            mtime_d = {mtime_q[63:32], mmio_wdata[31:0]};
        end
        5'h14: if (XLEN == 32) mtime_d = {mmio_wdata[31:0], mtime_q[31:0]};
        default: ;
      endcase
    end
  end

  always_comb begin
    mmio_rdata = '0;
    case (mmio_addr)
      5'h00: mmio_rdata[0] = msip_q;
      5'h08: mmio_rdata = XLEN'(mtimecmp_q);
      5'h0C: if (XLEN == 32) mmio_rdata = XLEN'(mtimecmp_q[63:32]);
      5'h10: mmio_rdata = XLEN'(mtime_q);
      5'h14: if (XLEN == 32) mmio_rdata = XLEN'(mtime_q[63:32]);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      ie_msi     <= 1'b0;
      ie_mti     <= 1'b0;
      ie_mei     <= 1'b0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      msip_q     <= 1'b0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      presc_q    <= '0;
    end else begin
      if (take_ecall || take_irq) begin
        mepc_q   <= epc & LOW2_MASK;
        st_mpie  <= st_mie;
        st_mie   <= 1'b0;
        mcause_q <= take_ecall ? XLEN'(ECALL_CAUSE) : (IRQ_FLAG | XLEN'(irq_cause));
      end else if (take_mret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end else if (csr_we) begin
        case (csr_addr)
          A_MSTATUS: begin
            st_mie  <= csr_new[3];
            st_mpie <= csr_new[7];
          end
          A_MIE: begin
            ie_msi <= csr_new[3];
            ie_mti <= csr_new[7];
            ie_mei <= csr_new[11];
          end
          A_MTVEC:    mtvec_q    <= mtvec_merge(mtvec_q, csr_new);
          A_MSCRATCH: mscratch_q <= csr_new;
          A_MEPC:     mepc_q     <= csr_new & LOW2_MASK;
          A_MCAUSE:   mcause_q   <= csr_new;
          default: ;
        endcase
      end
      presc_q    <= (presc_q == PRESC_LAST) ? 32'd0 : presc_q + 32'd1;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
    end
  end

endmodule

// File: tb/tb_csr_irq_unit.sv
// Bench for csr_irq_unit: a 64-bit instance checked against an architectural
// model, plus a 32-bit instance with a divided timer.
`timescale 1ns/1ps
module tb_csr_irq_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        rst, illegal_csr, insn_boundary, ecall, mret, irq_ext, mmio_we, trap_take;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [4:0]  mmio_addr;
  logic [63:0] csr_wdata, csr_rdata, epc, mmio_wdata, mmio_rdata, trap_target;

  csr_irq_unit #(.XLEN(64), .MTIME_DIV(1), .ECALL_CAUSE(11)) dut (
    .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .illegal_csr(illegal_csr), .insn_boundary(insn_boundary),
    .ecall(ecall), .mret(mret), .epc(epc), .irq_ext(irq_ext), .mmio_we(mmio_we),
    .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata),
    .trap_take(trap_take), .trap_target(trap_target));

  logic        b_rst, b_illegal_csr, b_insn_boundary, b_ecall, b_mret, b_irq_ext, b_mmio_we, b_trap_take;
  logic [11:0] b_csr_addr;
  logic [1:0]  b_csr_op;
  logic [4:0]  b_mmio_addr;
  logic [31:0] b_csr_wdata, b_csr_rdata, b_epc, b_mmio_wdata, b_mmio_rdata, b_trap_target;

  csr_irq_unit #(.XLEN(32), .MTIME_DIV(4), .ECALL_CAUSE(11)) dut_b (
    .clk(clk), .rst(b_rst), .csr_addr(b_csr_addr), .csr_op(b_csr_op), .csr_wdata(b_csr_wdata),
    .csr_rdata(b_csr_rdata), .illegal_csr(b_illegal_csr), .insn_boundary(b_insn_boundary),
    .ecall(b_ecall), .mret(b_mret), .epc(b_epc), .irq_ext(b_irq_ext), .mmio_we(b_mmio_we),
    .mmio_addr(b_mmio_addr), .mmio_wdata(b_mmio_wdata), .mmio_rdata(b_mmio_rdata),
    .trap_take(b_trap_take), .trap_target(b_trap_target));

  // Architectural model of the 64-bit instance, kept as whole registers.
  logic [63:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtime, m_mtimecmp;
  logic        m_msip;

  function automatic logic [63:0] m_mip();
    return {52'd0, irq_ext, 3'd0, (m_mtime >= m_mtimecmp), 3'd0, m_msip, 3'd0};
  endfunction

  function automatic logic m_impl(input logic [11:0] a);
    return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344};
  endfunction

  function automatic logic [63:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip();
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] m_mmio(input logic [4:0] a);
    case (a)
      5'h00:   return {63'd0, m_msip};
      5'h08:   return m_mtimecmp;
      5'h10:   return m_mtime;
      default: return 64'd0;
    endcase
  endfunction

  function automatic int m_irq_cause();
    logic [63:0] p;
    p = m_mip() & m_mie;
    if (!insn_boundary || !m_mstatus[3]) return -1;
    if (p[11]) return 11;
    if (p[3])  return 3;
    if (p[7])  return 7;
    return -1;
  endfunction

  function automatic logic m_take();
    return !rst && (ecall || mret || (m_irq_cause() >= 0));
  endfunction

  function automatic logic [63:0] m_target();
    logic [63:0] base;
    int c;
    base = {m_mtvec[63:2], 2'b00};
    c = m_irq_cause();
    if (rst)   return 64'd0;
    if (ecall) return base;
    if (mret)  return m_mepc;
    if (c >= 0) return m_mtvec[0] ? base + 64'(4 * c) : base;
    return 64'd0;
  endfunction

  // Advance the model by the effect of the currently driven inputs, then clock.
  task automatic tick();
    int c;
    logic [63:0] old_v, nv;
    c = m_irq_cause();
    old_v = m_read(csr_addr);
    case (csr_op)
      2'b01:   nv = csr_wdata;
      2'b10:   nv = old_v | csr_wdata;
      default: nv = old_v & ~csr_wdata;
    endcase
    if (rst) begin
      m_mstatus = 64'h1800; m_mie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
      m_msip = 0; m_mtime = 0; m_mtimecmp = '1;
    end else begin
      if (ecall || (!mret && c >= 0)) begin
        m_mepc    = epc & ~64'h3;
        m_mstatus = 64'h1800 | (m_mstatus[3] ? 64'h80 : 64'h0);
        m_mcause  = ecall ? 64'd11 : ((64'd1 << 63) | 64'(c));
      end else if (mret) begin
        m_mstatus = 64'h1880 | (m_mstatus[7] ? 64'h8 : 64'h0);
      end else if (csr_op != 2'b00) begin
        case (csr_addr)
          12'h300: m_mstatus  = 64'h1800 | (nv & 64'h88);
          12'h304: m_mie      = nv & 64'h888;
          12'h305: m_mtvec    = {nv[63:2], (nv[1:0] > 2'd1) ? m_mtvec[1:0] : nv[1:0]};
          12'h340: m_mscratch = nv;
          12'h341: m_mepc     = nv & ~64'h3;
          12'h342: m_mcause   = nv;
          default: ;
        endcase
      end
      if (mmio_we && mmio_addr == 5'h10) m_mtime = mmio_wdata;
      else                               m_mtime = m_mtime + 64'd1;
      if (mmio_we && mmio_addr == 5'h08) m_mtimecmp = mmio_wdata;
      if (mmio_we && mmio_addr == 5'h00) m_msip = mmio_wdata[0];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; csr_addr = 0; csr_op = 0; csr_wdata = 0; insn_boundary = 0; ecall = 0; mret = 0;
    epc = 0; irq_ext = 0; mmio_we = 0; mmio_addr = 0; mmio_wdata = 0;
  endtask

  task automatic csr_do(input logic [11:0] a, input logic [1:0] op, input logic [63:0] wd);
    csr_addr = a; csr_op = op; csr_wdata = wd;
    tick();
    csr_op = 0;
  endtask

  task automatic mmio_do(input logic [4:0] a, input logic [63:0] wd);
    mmio_we = 1; mmio_addr = a; mmio_wdata = wd;
    tick();
    mmio_we = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    logic [11:0] addrs [7];
    addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344};
    idle(); rst = 1; ecall = 1; insn_boundary = 1; epc = 64'h40;
    #1;
    total++; if (trap_take !== 1'b0) begin bad++; $display("FAIL reset_take got=%0b exp=0", trap_take); end
    total++; if (trap_target !== 64'd0) begin bad++; $display("FAIL reset_target got=%h exp=0", trap_target); end
    tick(); tick();
    idle();
    foreach (addrs[i]) begin
      csr_addr = addrs[i];
      #1;
      total++;
      if (csr_rdata !== ((addrs[i] == 12'h300) ? 64'h1800 : 64'h0)) begin
        bad++; $display("FAIL reset_csr_%h got=%h", addrs[i], csr_rdata);
      end
      tick();
    end
    mmio_addr = 5'h08; #1;
    total++; if (mmio_rdata !== '1) begin bad++; $display("FAIL reset_mtimecmp got=%h exp=all-ones", mmio_rdata); end
    tick();
    mmio_addr = 5'h0C; #1;
    total++; if (mmio_rdata !== 64'd0) begin bad++; $display("FAIL unmapped_0c got=%h exp=0", mmio_rdata); end
    tick();
    csr_addr = 12'h344; csr_op = 2'b01; csr_wdata = 64'hFFF; #1;
    total++; if (illegal_csr !== 1'b0) begin bad++; $display("FAIL mip_write_illegal got=%0b exp=0", illegal_csr); end
    tick(); csr_op = 0; #1;
    total++; if (csr_rdata !== 64'd0) begin bad++; $display("FAIL mip_after_write got=%h exp=0", csr_rdata); end
    tick();
    csr_addr = 12'h7C0; csr_op = 2'b01; csr_wdata = 64'h1234; #1;
    total++; if (illegal_csr !== 1'b1) begin bad++; $display("FAIL illegal_7c0 got=%0b exp=1", illegal_csr); end
    total++; if (csr_rdata !== 64'd0) begin bad++; $display("FAIL illegal_rdata got=%h exp=0", csr_rdata); end
    tick();
    idle();
  endtask

  task automatic test_timer_irq();
    bit seen;
    do_reset();
    csr_do(12'h305, 2'b01, 64'h8000_0001);
    csr_do(12'h304, 2'b01, 64'h80);
    csr_do(12'h300, 2'b01, 64'h8);
    mmio_do(5'h08, 64'd20);
    mmio_addr = 5'h10; insn_boundary = 1;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      #1;
      total++; if (trap_take !== m_take()) begin bad++; $display("FAIL timer_take cyc=%0d got=%0b exp=%0b", i, trap_take, m_take()); end
      if (trap_take) seen = 1;
      else tick();
    end
    total++; if (!seen) begin bad++; $display("FAIL timer_timeout got=no-trap exp=trap"); end
    total++; if (trap_target !== 64'h8000_001C) begin bad++; $display("FAIL timer_target got=%h exp=8000001c", trap_target); end
    total++; if (mmio_rdata !== 64'd20) begin bad++; $display("FAIL timer_mtime got=%0d exp=20", mmio_rdata); end
    tick();
    insn_boundary = 0; csr_addr = 12'h342; #1;
    total++; if (csr_rdata !== 64'h8000_0000_0000_0007) begin bad++; $display("FAIL timer_mcause got=%h", csr_rdata); end
    tick();
    csr_addr = 12'h300; #1;
    total++; if (csr_rdata !== 64'h1880) begin bad++; $display("FAIL timer_mstatus got=%h exp=1880", csr_rdata); end
    tick();
    mmio_do(5'h08, '1);
  endtask

  task automatic test_ecall_mret();
    csr_do(12'h300, 2'b01, 64'h8);
    ecall = 1; epc = 64'h1236; #1;
    total++; if (trap_take !== 1'b1) begin bad++; $display("FAIL ecall_take got=%0b exp=1", trap_take); end
    total++; if (trap_target !== 64'h8000_0000) begin bad++; $display("FAIL ecall_target got=%h exp=80000000", trap_target); end
    tick(); ecall = 0;
    csr_addr = 12'h341; #1;
    total++; if (csr_rdata !== 64'h1234) begin bad++; $display("FAIL ecall_mepc got=%h exp=1234", csr_rdata); end
    tick();
    csr_addr = 12'h342; #1;
    total++; if (csr_rdata !== 64'd11) begin bad++; $display("FAIL ecall_mcause got=%h exp=b", csr_rdata); end
    tick();
    mret = 1; #1;
    total++; if (trap_take !== 1'b1 || trap_target !== 64'h1234) begin bad++; $display("FAIL mret_target got=%h/%0b exp=1234/1", trap_target, trap_take); end
    tick(); mret = 0;
    csr_addr = 12'h300; #1;
    total++; if (csr_rdata !== 64'h1888) begin bad++; $display("FAIL mret_mstatus got=%h exp=1888", csr_rdata); end
    tick();
  endtask

  task automatic test_irq_priority();
    csr_do(12'h304, 2'b01, 64'h888);
    mmio_do(5'h00, 64'd1);
    irq_ext = 1; insn_boundary = 1; #1;
    total++; if (trap_take !== 1'b1 || trap_target !== 64'h8000_002C) begin bad++; $display("FAIL prio_mei got=%h/%0b exp=8000002c/1", trap_target, trap_take); end
    tick(); insn_boundary = 0;
    csr_addr = 12'h342; #1;
    total++; if (csr_rdata !== 64'h8000_0000_0000_000B) begin bad++; $display("FAIL prio_mei_cause got=%h", csr_rdata); end
    tick();
    irq_ext = 0; mret = 1; tick(); mret = 0;
    insn_boundary = 1; #1;
    total++; if (trap_take !== 1'b1 || trap_target !== 64'h8000_000C) begin bad++; $display("FAIL prio_msi got=%h/%0b exp=8000000c/1", trap_target, trap_take); end
    tick(); insn_boundary = 0;
    csr_addr = 12'h342; #1;
    total++; if (csr_rdata !== 64'h8000_0000_0000_0003) begin bad++; $display("FAIL prio_msi_cause got=%h", csr_rdata); end
    tick();
    mmio_do(5'h00, 64'd0);
    mret = 1; tick(); mret = 0;
  endtask

  task automatic test_ecall_suppress();
    csr_do(12'h340, 2'b01, 64'h55);
    irq_ext = 1; insn_boundary = 1; ecall = 1; epc = 64'h2000;
    csr_addr = 12'h340; csr_op = 2'b01; csr_wdata = 64'hDEAD; #1;
    total++; if (trap_take !== 1'b1 || trap_target !== 64'h8000_0000) begin bad++; $display("FAIL supp_target got=%h/%0b exp=80000000/1", trap_target, trap_take); end
    tick(); ecall = 0; csr_op = 0; insn_boundary = 0; #1;
    total++; if (csr_rdata !== 64'h55) begin bad++; $display("FAIL supp_mscratch got=%h exp=55", csr_rdata); end
    tick();
    insn_boundary = 1; #1;
    total++; if (trap_take !== 1'b0) begin bad++; $display("FAIL supp_masked got=%0b exp=0", trap_take); end
    mret = 1; #1;
    total++; if (trap_target !== 64'h2000) begin bad++; $display("FAIL supp_mret got=%h exp=2000", trap_target); end
    tick(); mret = 0; #1;
    total++; if (trap_take !== 1'b1 || trap_target !== 64'h8000_002C) begin bad++; $display("FAIL supp_late_irq got=%h/%0b exp=8000002c/1", trap_target, trap_take); end
    tick();
    idle(); mret = 1; tick(); mret = 0;
  endtask

  task automatic test_back_to_back();
    logic [11:0] addrs [8];
    logic [4:0]  maddrs [6];
    addrs  = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344, 12'h000};
    maddrs = '{5'h00, 5'h08, 5'h10, 5'h0C, 5'h14, 5'h1F};
    do_reset();
    for (int i = 0; i < 300; i++) begin
      rst           = ($urandom_range(0, 99) == 0);
      ecall         = ($urandom_range(0, 15) == 0);
      mret          = ($urandom_range(0, 15) == 0);
      insn_boundary = 1'($urandom_range(0, 1));
      irq_ext       = ($urandom_range(0, 3) == 0);
      csr_addr      = addrs[$urandom_range(0, 7)];
      if (csr_addr == 12'h000) csr_addr = 12'($urandom_range(0, 4095));
      csr_op        = 2'($urandom_range(0, 3));
      csr_wdata     = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) csr_wdata = 64'($urandom_range(0, 4095));
      epc           = {$urandom, $urandom};
      mmio_we       = ($urandom_range(0, 3) == 0);
      mmio_addr     = maddrs[$urandom_range(0, 5)];
      mmio_wdata    = (mmio_addr == 5'h00) ? 64'($urandom_range(0, 1)) : 64'($urandom_range(0, 80));
      #1;
      total++; if (trap_take !== m_take()) begin bad++; $display("FAIL rnd_take cyc=%0d got=%0b exp=%0b", i, trap_take, m_take()); end
      if (m_take()) begin
        total++; if (trap_target !== m_target()) begin bad++; $display("FAIL rnd_target cyc=%0d got=%h exp=%h", i, trap_target, m_target()); end
      end
      total++; if (csr_rdata !== m_read(csr_addr)) begin bad++; $display("FAIL rnd_rdata cyc=%0d addr=%h got=%h exp=%h", i, csr_addr, csr_rdata, m_read(csr_addr)); end
      total++; if (illegal_csr !== (csr_op != 0 && !m_impl(csr_addr))) begin bad++; $display("FAIL rnd_illegal cyc=%0d got=%0b", i, illegal_csr); end
      total++; if (mmio_rdata !== m_mmio(mmio_addr)) begin bad++; $display("FAIL rnd_mmio cyc=%0d addr=%h got=%h exp=%h", i, mmio_addr, mmio_rdata, m_mmio(mmio_addr)); end
      tick();
    end
    do_reset();
  endtask

  task automatic test_xlen32();
    b_rst = 1; tick(); b_rst = 0;
    b_mmio_addr = 5'h10;
    for (int n = 1; n <= 13; n++) begin
      tick();
      total++; if (b_mmio_rdata !== 32'(n / 4)) begin bad++; $display("FAIL x32_mtime n=%0d got=%0d exp=%0d", n, b_mmio_rdata, n / 4); end
    end
    b_mmio_we = 1; b_mmio_addr = 5'h14; b_mmio_wdata = 32'd5; tick(); b_mmio_we = 0; #1;
    total++; if (b_mmio_rdata !== 32'd5) begin bad++; $display("FAIL x32_mtime_hi got=%0d exp=5", b_mmio_rdata); end
    tick();
    b_mmio_we = 1; b_mmio_addr = 5'h0C; b_mmio_wdata = 32'd1; tick(); b_mmio_we = 0; #1;
    total++; if (b_mmio_rdata !== 32'd1) begin bad++; $display("FAIL x32_cmp_hi got=%h exp=1", b_mmio_rdata); end
    b_mmio_addr = 5'h08; #1;
    total++; if (b_mmio_rdata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL x32_cmp_lo got=%h exp=ffffffff", b_mmio_rdata); end
    tick();
    b_csr_addr = 12'h304; b_csr_op = 2'b10; b_csr_wdata = 32'h888; tick();
    b_csr_op = 2'b11; b_csr_wdata = 32'h008; tick();
    b_csr_op = 2'b00; #1;
    total++; if (b_csr_rdata !== 32'h880) begin bad++; $display("FAIL x32_mie got=%h exp=880", b_csr_rdata); end
    tick();
    b_csr_addr = 12'h305; b_csr_op = 2'b01; b_csr_wdata = 32'h100; tick(); b_csr_op = 2'b00;
    b_ecall = 1; b_epc = 32'h77; #1;
    total++; if (b_trap_take !== 1'b1 || b_trap_target !== 32'h100) begin bad++; $display("FAIL x32_ecall got=%h/%0b exp=100/1", b_trap_target, b_trap_take); end
    tick(); b_ecall = 0;
    b_csr_addr = 12'h341; #1;
    total++; if (b_csr_rdata !== 32'h74) begin bad++; $display("FAIL x32_mepc got=%h exp=74", b_csr_rdata); end
    tick();
  endtask

  initial begin
    idle();
    b_rst = 1; b_csr_addr = 0; b_csr_op = 0; b_csr_wdata = 0; b_insn_boundary = 0; b_ecall = 0;
    b_mret = 0; b_epc = 0; b_irq_ext = 0; b_mmio_we = 0; b_mmio_addr = 0; b_mmio_wdata = 0;
    m_mstatus = 64'h1800; m_mie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
    m_msip = 0; m_mtime = 0; m_mtimecmp = '1;
    test_reset();
    test_timer_irq();
    test_ecall_mret();
    test_irq_priority();
    test_ecall_suppress();
    test_back_to_back();
    test_xlen32();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
